nibble_stream_decryptor: RTL

NIBBLE_STREAM_DECRYPTOR -- requirements
Module: nibble_stream_decryptor

---
 rtl/nibble_cipher_pkg.sv | 21 ++
 rtl/keystream_lfsr.sv | 37 +++
 rtl/nibble_stream_decryptor.sv | 100 ++++++++++
 3 files changed

// File: rtl/nibble_cipher_pkg.sv
// Shared definitions for the nibble stream cipher (encryptor and decryptor).
// Holds the keystream LFSR geometry, taps, default seed and the step function.
package nibble_cipher_pkg;

  localparam int          LFSR_W       = 8;
  localparam logic [7:0]  LFSR_TAPS    = 8'hB8;
  localparam logic [7:0]  DEFAULT_SEED = 8'h01;

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dec_state_e;

  // One Galois step: shift right, fold the taps in when the outgoing bit is set.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {1'b0, v[LFSR_W-1:1]} ^ (v[0] ? LFSR_TAPS : {LFSR_W{1'b0}});
  endfunction

endpackage

// File: rtl/keystream_lfsr.sv
// 8-bit Galois LFSR keystream generator; a zero seed is replaced by SEED_FIX
// because the all-zero state would lock the register.
module keystream_lfsr
  import nibble_cipher_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED_FIX = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output nibble_t           ks
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == '0) ? SEED_FIX : seed;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_FIX;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign ks = lfsr_q[3:0];

endmodule

// File: rtl/nibble_stream_decryptor.sv
// Streaming nibble decryptor: XORs each accepted ciphertext nibble with the LFSR
// keystream. Optional delivered-nibble counter is built when NIBBLE_DEC_COUNT_EN is defined.
module nibble_stream_decryptor
  import nibble_cipher_pkg::*;
#(
  parameter int                CNT_W    = 16,
  parameter logic [LFSR_W-1:0] SEED_FIX = DEFAULT_SEED
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_valid,
  input  logic [3:0]        i_message,
  output logic              o_ready,
  output logic              o_valid,
  output logic [3:0]        o_decrypted_message,
  input  logic              i_ready,
  output logic [CNT_W-1:0]  o_count
);

  dec_state_e state_q, state_d;
  logic       valid_q, valid_d;
  nibble_t    data_q,  data_d;
  nibble_t    ks;
  logic       accept;
  logic       xfer;

  // Seed load blocks acceptance so the LFSR never loads and steps on one edge.
  assign o_ready = (state_q == ST_RUN) && !i_seed_load && (!valid_q || i_ready);
  assign accept  = i_valid && o_ready;
  assign xfer    = valid_q && i_ready;

  keystream_lfsr #(
    .SEED_FIX (SEED_FIX)
  ) u_lfsr (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .load  (i_seed_load),
    .seed  (i_seed),
    .step  (accept),
    .ks    (ks)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (i_seed_load) begin
      state_d = ST_RUN;
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      data_d  = i_message ^ ks;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid             = valid_q;
  assign o_decrypted_message = data_q;

`ifdef NIBBLE_DEC_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_seed_load) begin
      count_d = '0;
    end else if (xfer) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
`else
  assign o_count = '0;
`endif

endmodule
